// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle for one RAM client: request in, grant and
// response out.
interface ram_port_arbiter_if #(
   parameter int DW = 16,
   parameter int AW = 16
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;
   logic          err;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin; default is m1 priority.
module ram_port_arbiter #(
   parameter int DW    = 16,
   parameter int AW    = 16,
   parameter int DEPTH = 4096
) (
   input  logic          clk,
   input  logic          rst,
   ram_port_arbiter_if.slave m0,
   ram_port_arbiter_if.slave m1,
   output logic [AW-1:0] ram_adrs,
   output logic [DW-1:0] ram_data,
   output logic          ram_we,
   input  logic [DW-1:0] ram_val
);

   localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_NONE,
      S_OWN0,
      S_OWN1
   } own_t;

   own_t          r_owner;
   own_t          w_owner_nxt;
   logic          r_err;
   logic          w_err_nxt;
   logic          w_g0;
   logic          w_g1;
   logic          w_any;
   logic          w_oor;
   logic          w_we;
   logic [AW-1:0] w_adrs;
   logic [DW-1:0] w_data;
   logic [AW-1:0] r_adrs;
   logic [DW-1:0] r_data;
   logic [DW-1:0] r_hold0;
   logic [DW-1:0] r_hold1;
   logic [DW-1:0] w_resp;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   // r_last = 1 when m1 held the most recent grant
   logic r_last;

   always_ff @(posedge clk) begin
      if (rst)
         r_last <= 1'b1;
      else if (w_g0)
         r_last <= 1'b0;
      else if (w_g1)
         r_last <= 1'b1;
   end

   always_comb begin
      w_g0 = 1'b0;
      w_g1 = 1'b0;
      if (!rst) begin
         if (m0.req && m1.req) begin
            w_g0 = r_last;
            w_g1 = !r_last;
         end else begin
            w_g0 = m0.req;
            w_g1 = m1.req;
         end
      end
   end
`else
   always_comb begin
      w_g1 = !rst && m1.req;
      w_g0 = !rst && m0.req && !m1.req;
   end
`endif

   assign m0.gnt = w_g0;
   assign m1.gnt = w_g1;
   assign w_any  = w_g0 || w_g1;

   always_comb begin
      w_adrs = w_g1 ? m1.addr  : m0.addr;
      w_data = w_g1 ? m1.wdata : m0.wdata;
      w_we   = w_g1 ? m1.we    : m0.we;
   end

   assign w_oor    = {1'b0, w_adrs} >= LIM;
   assign ram_we   = w_any && w_we && !w_oor;
   assign ram_adrs = w_any ? w_adrs : r_adrs;
   assign ram_data = w_any ? w_data : r_data;

   // Idle cycles replay the last issued address/data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_adrs <= '0;
         r_data <= '0;
      end else if (w_any) begin
         r_adrs <= w_adrs;
         r_data <= w_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner <= S_NONE;
         r_err   <= 1'b0;
      end else begin
         r_owner <= w_owner_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_owner_nxt = S_NONE;
      w_err_nxt   = w_any && w_oor;
      unique case (1'b1)
         w_g0:    w_owner_nxt = S_OWN0;
         w_g1:    w_owner_nxt = S_OWN1;
         default: w_owner_nxt = S_NONE;
      endcase
   end

   assign w_resp = r_err ? '0 : ram_val;

   always_comb begin
      m0.rvalid = 1'b0;
      m0.err    = 1'b0;
      m0.rdata  = r_hold0;
      m1.rvalid = 1'b0;
      m1.err    = 1'b0;
      m1.rdata  = r_hold1;
      if (!rst) begin
         unique case (r_owner)
            S_OWN0: begin
               m0.rvalid = 1'b1;
               m0.err    = r_err;
               m0.rdata  = w_resp;
            end
            S_OWN1: begin
               m1.rvalid = 1'b1;
               m1.err    = r_err;
               m1.rdata  = w_resp;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold0 <= '0;
         r_hold1 <= '0;
      end else begin
         if (r_owner == S_OWN0) r_hold0 <= w_resp;
         if (r_owner == S_OWN1) r_hold1 <= w_resp;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: RAM model plus hand-computed expectations.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        preload;
   logic [15:0] ram_adrs;
   logic [15:0] ram_data;
   logic        ram_we;
   logic [15:0] ram_val;
   logic [15:0] mem [0:65535];

   int n_chk = 0;
   int n_err = 0;
   bit exp_last;
   bit prev_g0, prev_g1;
   int cnt0, cnt1;

   ram_port_arbiter_if u_m0 ();
   ram_port_arbiter_if u_m1 ();

   ram_port_arbiter u_dut (
      .clk      (clk),
      .rst      (rst),
      .m0       (u_m0),
      .m1       (u_m1),
      .ram_adrs (ram_adrs),
      .ram_data (ram_data),
      .ram_we   (ram_we),
      .ram_val  (ram_val)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (preload) begin
         mem[16'h0000] <= 16'hA5A5;
         mem[16'h0010] <= 16'h1234;
         mem[16'h0020] <= 16'h0000;
         ram_val       <= 16'h0000;
      end else if (ram_we) begin
         mem[ram_adrs] <= ram_data;
         ram_val       <= ram_data;
      end else begin
         ram_val <= mem[ram_adrs];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      u_m0.req = 0; u_m0.we = 0;
      u_m1.req = 0; u_m1.we = 0;
   endtask

   task automatic rq0(input logic we, input logic [15:0] a,
                      input logic [15:0] d);
      u_m0.req = 1; u_m0.we = we; u_m0.addr = a; u_m0.wdata = d;
   endtask

   task automatic rq1(input logic we, input logic [15:0] a,
                      input logic [15:0] d);
      u_m1.req = 1; u_m1.we = we; u_m1.addr = a; u_m1.wdata = d;
   endtask

   initial begin
      rst = 1; preload = 1;
      u_m0.addr = 0; u_m0.wdata = 0;
      u_m1.addr = 0; u_m1.wdata = 0;
      idle();
      tick();
      preload = 0;
      rq0(0, 16'h0010, 0);
      rq1(0, 16'h0000, 0);
      #1;
      chk("rst_gnt0", u_m0.gnt, 0);
      chk("rst_gnt1", u_m1.gnt, 0);
      chk("rst_we", ram_we, 0);
      tick();
      chk("rst_rv0", u_m0.rvalid, 0);
      chk("rst_rv1", u_m1.rvalid, 0);
      chk("rst_rd0", u_m0.rdata, 0);
      chk("rst_err1", u_m1.err, 0);
      idle();
      rst = 0;
      exp_last = 1;

      // T1: plain m0 read
      tick();
      rq0(0, 16'h0010, 0);
      #1;
      chk("t1_gnt0", u_m0.gnt, 1);
      chk("t1_gnt1", u_m1.gnt, 0);
      chk("t1_adr", ram_adrs, 16'h0010);
      chk("t1_we", ram_we, 0);
      exp_last = 0;
      tick();
      idle();
      chk("t1_rv0", u_m0.rvalid, 1);
      chk("t1_rd0", u_m0.rdata, 16'h1234);
      chk("t1_err0", u_m0.err, 0);
      chk("t1_rv1", u_m1.rvalid, 0);

      // T2: write then read-after-write
      rq1(1, 16'h0020, 16'hBEEF);
      #1;
      chk("t2_gnt1", u_m1.gnt, 1);
      chk("t2_we", ram_we, 1);
      tick();
      idle();
      rq0(0, 16'h0020, 0);
      chk("t2_rv1", u_m1.rvalid, 1);
      chk("t2_rd1", u_m1.rdata, 16'hBEEF);
      chk("t2_rv0", u_m0.rvalid, 0);
      #1;
      chk("t2_gnt0", u_m0.gnt, 1);
      exp_last = 0;
      tick();
      idle();
      chk("t2_rv0b", u_m0.rvalid, 1);
      chk("t2_rd0", u_m0.rdata, 16'hBEEF);
      chk("t2_rv1b", u_m1.rvalid, 0);
      chk("t2_hold1", u_m1.rdata, 16'hBEEF);

      // T3: contention for 6 cycles
      cnt0 = 0; cnt1 = 0;
      prev_g0 = 0; prev_g1 = 0;
      for (int i = 0; i < 6; i++) begin
         bit e1;
         rq0(0, 16'h0010, 0);
         rq1(0, 16'h0000, 0);
`ifdef RAM_ARB_ROUND_ROBIN_EN
         e1 = !exp_last;
`else
         e1 = 1;
`endif
         #1;
         chk("t3_gnt1", u_m1.gnt, e1);
         chk("t3_gnt0", u_m0.gnt, !e1);
         if (u_m1.gnt) cnt1++;
         if (u_m0.gnt) cnt0++;
         exp_last = e1;
         tick();
         chk("t3_rv1", u_m1.rvalid, e1);
         chk("t3_rv0", u_m0.rvalid, !e1);
         if (e1) chk("t3_rd1", u_m1.rdata, 16'hA5A5);
         else    chk("t3_rd0", u_m0.rdata, 16'h1234);
      end
      idle();
`ifdef RAM_ARB_ROUND_ROBIN_EN
      chk("t3_cnt1", cnt1, 3);
      chk("t3_cnt0", cnt0, 3);
`else
      chk("t3_cnt1", cnt1, 6);
      chk("t3_cnt0", cnt0, 0);
`endif

      // T4: out-of-range write is blocked
      rq1(1, 16'h1000, 16'h5555);
      #1;
      chk("t4_gnt1", u_m1.gnt, 1);
      chk("t4_we", ram_we, 0);
      tick();
      idle();
      chk("t4_rv1", u_m1.rvalid, 1);
      chk("t4_err1", u_m1.err, 1);
      chk("t4_rd1", u_m1.rdata, 0);
      rq1(0, 16'h0000, 0);
      #1;
      tick();
      idle();
      chk("t4_rv1b", u_m1.rvalid, 1);
      chk("t4_err1b", u_m1.err, 0);
      chk("t4_rd1b", u_m1.rdata, 16'hA5A5);

      // T5: reset drops the in-flight response
      rq0(0, 16'h0010, 0);
      #1;
      chk("t5_gnt0", u_m0.gnt, 1);
      tick();
      idle();
      rst = 1;
      #1;
      chk("t5_rv0", u_m0.rvalid, 0);
      chk("t5_we", ram_we, 0);
      tick();
      rst = 0;
      chk("t5_rv0b", u_m0.rvalid, 0);
      chk("t5_rd0", u_m0.rdata, 0);
      chk("t5_rd1", u_m1.rdata, 0);
      chk("t5_err0", u_m0.err, 0);
      chk("t5_adr", ram_adrs, 0);
      exp_last = 1;

      // T6: idle after a write
      tick();
      rq0(1, 16'h0030, 16'h7777);
      #1;
      chk("t6_we", ram_we, 1);
      tick();
      idle();
      chk("t6_rv0", u_m0.rvalid, 1);
      chk("t6_rd0", u_m0.rdata, 16'h7777);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t6_idle_we", ram_we, 0);
         chk("t6_idle_adr", ram_adrs, 16'h0030);
         tick();
         chk("t6_idle_rv0", u_m0.rvalid, 0);
         chk("t6_idle_rv1", u_m1.rvalid, 0);
         chk("t6_hold0", u_m0.rdata, 16'h7777);
      end
      rq0(0, 16'h0030, 0);
      #1;
      tick();
      idle();
      chk("t6_rb", u_m0.rdata, 16'h7777);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
